// File: rtl/aes_encryption.sv
// ---------------------------------------------------------------------------
// aes_encryption -- iterative AES-128 encryption core.
//
// One round per clock.  The key schedule is expanded once per key_init,
// one round key per cycle, into eleven 128-bit registers.  A block is then
// encrypted in ten cycles, one round per cycle, by reusing those keys.
//
// Ports:
//   aclk          sole clock, rising edge
//   areset        synchronous active-high reset
//   key_init      one-cycle request to load key and expand it
//   keylen        key length select sampled with key_init (1 = AES-128)
//   key           128-bit cipher key, byte 0 in the MSBs
//   key_ready     round-key set complete and valid
//   next          one-cycle request to encrypt input_block
//   input_block   128-bit plaintext, byte 0 in the MSBs
//   output_block  128-bit ciphertext register
//   block_ready   output_block holds the result of the last accepted next
//
// Also contains aes_sbox, the shared combinational byte substitution.
// ---------------------------------------------------------------------------

// aes_sbox: AES S-box, computed as the GF(2^8) multiplicative inverse
// (x^254, which maps 0 to 0) followed by the affine transform.
//   in_byte   byte to substitute
//   out_byte  substituted byte
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 = x^2 * x^4 * ... * x^128, built by repeated squaring
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] dbl;
        dbl = {b, b} << n;
        return dbl[15:8];
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv      = gf_inv(in_byte);
        out_byte = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

endmodule

module aes_encryption (
    input  logic         aclk,
    input  logic         areset,
    input  logic         key_init,
    input  logic         keylen,
    input  logic [127:0] key,
    output logic         key_ready,
    input  logic         next,
    input  logic [127:0] input_block,
    output logic [127:0] output_block,
    output logic         block_ready
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] KEXP = 2'd1;
    localparam logic [1:0] ENC  = 2'd2;

    logic [1:0]   state;
    logic [3:0]   round;
    logic [127:0] rk [0:10];
    logic [127:0] aes_state;

    // The same counter indexes the key being produced during KEXP and the
    // key being applied during ENC.  Clamping keeps the index inside the
    // eleven-entry array even though 11..15 are never reached.
    logic [3:0]   cur_idx;
    logic [3:0]   prev_idx;
    logic [127:0] cur_rk;
    logic [127:0] prev_rk;

    assign cur_idx  = (round > 4'd10) ? 4'd10 : round;
    assign prev_idx = (cur_idx == 4'd0) ? 4'd0 : cur_idx - 4'd1;
    assign cur_rk   = rk[cur_idx];
    assign prev_rk  = rk[prev_idx];

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    // Key schedule: RotWord then SubWord on the last word of the previous key
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [31:0]  w0;
    logic [31:0]  w1;
    logic [31:0]  w2;
    logic [31:0]  w3;
    logic [127:0] next_rk;

    assign rot_word = {prev_rk[23:0], prev_rk[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_key_sbox
        aes_sbox u_sbox (
            .in_byte  (rot_word[31-8*g -: 8]),
            .out_byte (sub_word[31-8*g -: 8])
        );
    end

    assign w0      = prev_rk[127:96] ^ sub_word ^ {rcon(cur_idx), 24'h000000};
    assign w1      = prev_rk[95:64] ^ w0;
    assign w2      = prev_rk[63:32] ^ w1;
    assign w3      = prev_rk[31:0] ^ w2;
    assign next_rk = {w0, w1, w2, w3};

    // Round datapath; byte n of the block sits at bits 127-8n, column c
    // holds bytes 4c..4c+3 and row r of column c is byte 4c+r.
    logic [127:0] sub_bytes;
    logic [127:0] shifted;
    logic [127:0] mixed;
    logic [127:0] round_out;
    logic [127:0] final_out;

    for (genvar g = 0; g < 16; g++) begin : g_data_sbox
        aes_sbox u_sbox (
            .in_byte  (aes_state[127-8*g -: 8]),
            .out_byte (sub_bytes[127-8*g -: 8])
        );
    end

    // ShiftRows: row r rotates left by r columns
    always_comb begin
        shifted = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127-8*(4*c+r) -: 8] = sub_bytes[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
    end

    assign mixed     = {mix_column(shifted[127:96]), mix_column(shifted[95:64]),
                        mix_column(shifted[63:32]),  mix_column(shifted[31:0])};
    assign round_out = mixed ^ cur_rk;
    assign final_out = shifted ^ cur_rk;

    // key_init with a valid length overrides whatever is in progress,
    // including an encryption, so output_block keeps its previous result.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state        <= IDLE;
            round        <= 4'd0;
            key_ready    <= 1'b0;
            block_ready  <= 1'b0;
            output_block <= '0;
            aes_state    <= '0;
            for (int i = 0; i < 11; i++) begin
                rk[i] <= '0;
            end
        end else if (key_init && keylen) begin
            rk[0]     <= key;
            key_ready <= 1'b0;
            round     <= 4'd1;
            state     <= KEXP;
        end else begin
            case (state)
                KEXP: begin
                    rk[cur_idx] <= next_rk;
                    if (round == 4'd10) begin
                        state     <= IDLE;
                        round     <= 4'd0;
                        key_ready <= 1'b1;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                ENC: begin
                    if (round == 4'd10) begin
                        output_block <= final_out;
                        block_ready  <= 1'b1;
                        state        <= IDLE;
                        round        <= 4'd0;
                    end else begin
                        aes_state <= round_out;
                        round     <= round + 4'd1;
                    end
                end
                default: begin
                    if (next && key_ready) begin
                        aes_state   <= input_block ^ rk[0];
                        round       <= 4'd1;
                        block_ready <= 1'b0;
                        state       <= ENC;
                    end
                end
            endcase
        end
    end

endmodule
